// File: rtl/axi4l_master_bridge_pkg.sv
// Shared constants and types for the AXI4-Lite master bridge: response codes,
// protection default and the transaction FSM encoding.
package axi4l_master_bridge_pkg;

    localparam int RESP_W = 2;
    localparam int PROT_W = 3;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    localparam logic [PROT_W-1:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_WRESP = 3'd2,
        S_READ  = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    // AXI4-Lite has no exclusive access, so anything but OKAY is an error.
    function automatic logic resp_is_err(input logic [RESP_W-1:0] resp);
        case (resp)
            RESP_OKAY:                             return 1'b0;
            RESP_EXOKAY, RESP_SLVERR, RESP_DECERR: return 1'b1;
            default:                               return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/axi4l_master_bridge_if.sv
// AXI4-Lite bus bundle between the bridge (master) and the system interconnect (slave).
interface axi4l_master_bridge_if
    import axi4l_master_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [PROT_W-1:0]   awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [RESP_W-1:0]   bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [PROT_W-1:0]   arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [RESP_W-1:0]   rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );
endinterface

// File: rtl/axi4l_master_bridge_wdog.sv
// Transaction watchdog: counts cycles since acceptance (accept cycle included)
// and flags expiry on the cycle whose closing edge would reach TIMEOUT.
module axi4l_master_bridge_wdog
    import axi4l_master_bridge_pkg::*;
#(
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'((TIMEOUT > 1) ? 1 : 0);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = LOAD;
        else if (en_i && !expired_o)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = (TIMEOUT > 0) && en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/axi4l_master_bridge.sv
// Single-outstanding AXI4-Lite master: turns one core load/store request into
// an AW/W or AR transaction and returns a one-cycle response pulse.
module axi4l_master_bridge
    import axi4l_master_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_wstrb_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    axi4l_master_bridge_if.master m_axi
);
    state_e state_q, state_d;

    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;

    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                arvalid_q, arvalid_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic accept, busy, aw_done, w_done, wdog_expired;

    // req_ready is held low while reset is asserted, not just in the state after it.
    assign req_ready_o = rst_n && (state_q == S_IDLE);
    assign busy        = (state_q == S_WRITE) || (state_q == S_WRESP) ||
                         (state_q == S_READ)  || (state_q == S_RDATA);
    assign aw_done     = !awvalid_q || m_axi.awready;
    assign w_done      = !wvalid_q  || m_axi.wready;

    axi4l_master_bridge_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (accept),
        .en_i      (busy),
        .expired_o (wdog_expired)
    );

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        accept      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    accept = 1'b1;
                    if (req_we_i) begin
                        state_d   = S_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_READ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                // AW and W complete independently; B is awaited only once both have.
                if (m_axi.awready) awvalid_d = 1'b0;
                if (m_axi.wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) state_d = S_WRESP;
            end
            S_WRESP: begin
                if (m_axi.bvalid) begin
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = resp_is_err(m_axi.bresp);
                end
            end
            S_READ: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (m_axi.rvalid) begin
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = resp_is_err(m_axi.rresp);
                    rsp_rdata_d = m_axi.rdata;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abandon the slave: readies fall with the state, late beats are never taken.
        if (wdog_expired) begin
            state_d     = S_DONE;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            arvalid_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Payload holds from accept until the next accept, covering every valid window.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            wstrb_q <= req_wstrb_i;
        end
    end

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = PROT_DEFAULT;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = (state_q == S_WRESP);
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = PROT_DEFAULT;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = (state_q == S_RDATA);

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: doc/axi4l_master_bridge.md
# axi4l_master_bridge

Single-outstanding AXI4-Lite master that converts the core's simple load/store request/response interface into AXI4-Lite transactions on the system bus, opposite end of the AXI4-Lite slave ports exposed by iram and peripherals. It accepts one request at a time, drives AW/W or AR, collects B or R, and returns a one-cycle response pulse with data and error flag. An optional watchdog terminates transactions whose slave never responds.

## Interface
- `ADDR_W`, default 32: address width, matches `` `MemAddrBus ``.
- `DATA_W`, default 32: data width, matches `` `MemBus ``; strobe width is `DATA_W/8`.
- `TIMEOUT`, default 0: cycles allowed per transaction after acceptance; 0 disables the watchdog.
- `clk` in, 1: single clock.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `req_valid` in, 1: core request present.
- `req_ready` out, 1: bridge idle, request accepted when `req_valid & req_ready`.
- `req_we` in, 1: 1 = write, 0 = read.
- `req_addr` in, ADDR_W: byte address, passed unmodified.
- `req_wdata` in, DATA_W: write data.
- `req_wstrb` in, DATA_W/8: byte enables (ignored on read).
- `rsp_valid` out, 1: one-cycle completion pulse.
- `rsp_rdata` out, DATA_W: read data, valid with `rsp_valid` on reads; 0 on writes.
- `rsp_err` out, 1: with `rsp_valid`, set when RESP ≠ OKAY or the watchdog fired.
- AXI master ports: `m_axi_awaddr/awprot/awvalid` out, `m_axi_awready` in; `m_axi_wdata/wstrb/wvalid` out, `m_axi_wready` in; `m_axi_bresp/bvalid` in, `m_axi_bready` out; `m_axi_araddr/arprot/arvalid` out, `m_axi_arready` in; `m_axi_rdata/rresp/rvalid` in, `m_axi_rready` out. Widths per AXI4-Lite (prot 3, resp 2).

## Operation
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, DONE.
- IDLE: `req_ready`=1. On accept, latch addr/wdata/wstrb; go WRITE (we=1) or READ (we=0).
- WRITE: `awvalid` and `wvalid` both rise in the same cycle (slaves in this design require both simultaneously). Each valid is held until its own ready is sampled high, then dropped independently; track `aw_done`/`w_done`. When both complete (same or different cycles) go WRESP.
- WRESP: `bready`=1; on `bvalid`, capture `bresp`, go DONE.
- READ: `arvalid`=1 until `arready`; then RDATA.
- RDATA: `rready`=1; on `rvalid`, capture `rdata`/`rresp`, go DONE.
- DONE: `rsp_valid`=1 for exactly one cycle, `rsp_err` = (captured resp ≠ 2'b00); return to IDLE.
- AXI payload signals stay stable while their valid is high; `awprot`/`arprot` constant 3'b000.
- Watchdog (TIMEOUT>0): counter cleared on accept, increments in every non-IDLE/non-DONE state; on reaching TIMEOUT, drop all valids/readies, go DONE with `rsp_err`=1, `rsp_rdata`=0. A late B/R beat from the abandoned slave is ignored (readies low).
- Reset (asynchronous, any state): FSM → IDLE; all valids, readies, `rsp_valid`, `rsp_err` → 0; `rsp_rdata` → 0; `req_ready` → 1 only after reset deasserts. In-flight transaction is dropped, no response issued.

## Timing
- Outputs registered except `req_ready`, `bready`, `rready` (decoded from state).
- Against a zero-wait slave (ready combinational, B/R one cycle later): accept at cycle 0, AW/W or AR handshake at cycle 1, B/R handshake at cycle 2, `rsp_valid` at cycle 3. Back-to-back request accepted at cycle 4; throughput one transaction per 4 cycles.
- Each added ready or B/R wait cycle adds one cycle of latency.
- No combinational path from any AXI input to any AXI output.

## Structure
- Shared constants in `defines.v`: AXI RESP codes (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11) and FSM state encodings.
- Optional sub-module `axi4l_wdog`: loadable up-counter with `clr`, `en`, `expired`; otherwise single module.

## Test plan
- Write addr 0x0000_0010, data 0xDEAD_BEEF, strb 4'hF to zero-wait slave → AW/W together at cycle 1, `rsp_valid` at cycle 3, `rsp_err`=0, memory holds 0xDEAD_BEEF.
- Read back 0x10 → `rsp_rdata`=0xDEAD_BEEF at cycle 3, `rsp_err`=0.
- Slave asserts `wready` 2 cycles before `awready` → `wvalid` drops after its handshake, `awvalid` held until its own, exactly one B accepted.
- Slave returns `rresp`=2'b10 with data 0x1234 → `rsp_err`=1, `rsp_rdata`=0x1234.
- TIMEOUT=8, slave never asserts `arready` → `rsp_valid` with `rsp_err`=1 eight cycles after accept, `arvalid` low afterwards, next request accepted.
- `rst_n` low while `bvalid` pending → all AXI valids/readies 0 immediately, no `rsp_valid`; after release, a new write completes normally.
